// File: rtl/muldiv_control_unit_if.sv
// Control bus between the muldiv sequencer and the bus datapath / memory.
// master = sequencer side, slave = datapath side.
interface muldiv_control_unit_if #(
    parameter int BITS      = 64,
    parameter int REGISTERS = 16
);
    logic                 run;
    logic                 mem_ready;
    logic [BITS-1:0]      IRVal;
    logic                 PCout, Zlowout, Zhighout, MDRout, HIout, LOout;
    logic                 PCin, IRin, RYin, RZin, MARin, MDRin;
    logic                 HIin, LOin, IncPC, Read;
    logic                 ADD, SUB, MUL, DIV, SHR, SHL;
    logic                 ROR, ROL, AND, OR, NEGATE, NOT;
    logic [REGISTERS-1:0] GPRin, GPRout;
    logic                 busy, instr_done, illegal_op;

    modport master (
        input  run, mem_ready, IRVal,
        output PCout, Zlowout, Zhighout, MDRout, HIout, LOout,
        output PCin, IRin, RYin, RZin, MARin, MDRin,
        output HIin, LOin, IncPC, Read,
        output ADD, SUB, MUL, DIV, SHR, SHL,
        output ROR, ROL, AND, OR, NEGATE, NOT,
        output GPRin, GPRout, busy, instr_done, illegal_op
    );

    modport slave (
        output run, mem_ready, IRVal,
        input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout,
        input  PCin, IRin, RYin, RZin, MARin, MDRin,
        input  HIin, LOin, IncPC, Read,
        input  ADD, SUB, MUL, DIV, SHR, SHL,
        input  ROR, ROL, AND, OR, NEGATE, NOT,
        input  GPRin, GPRout, busy, instr_done, illegal_op
    );
endinterface

// File: rtl/muldiv_control_unit.sv
// Hardwired fetch/execute sequencer for the bus datapath.
// Optional CU_MULDIV_EN macro enables mul/div decode (default: illegal).
module muldiv_control_unit #(
    parameter int BITS      = 64,
    parameter int REGISTERS = 16
) (
    input  logic                   Clock,
    input  logic                   reset,
    muldiv_control_unit_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6
    } state_t;

    state_t state, state_nxt;

    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    logic       is_alu3, is_un, is_md, op_go;
    logic       unused_ir;

    assign opc = bus.IRVal[31:27];
    assign ra  = bus.IRVal[26:23];
    assign rb  = bus.IRVal[22:19];
    assign rc  = bus.IRVal[18:15];
    assign unused_ir = ^{bus.IRVal[BITS-1:32], bus.IRVal[14:0]};

    // Out-of-range register indices select nothing.
    function automatic logic [REGISTERS-1:0] gpr_sel(input logic [3:0] idx);
        logic [REGISTERS-1:0] oh;
        for (int i = 0; i < REGISTERS; i++) begin
            oh[i] = (int'(idx) == i);
        end
        return oh;
    endfunction

    assign is_alu3 = (opc >= 5'b00011) && (opc <= 5'b01010);
    assign is_un   = (opc == 5'b10001) || (opc == 5'b10010);
`ifdef CU_MULDIV_EN
    assign is_md   = (opc == 5'b01111) || (opc == 5'b10000);
`else
    assign is_md   = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        op_go          = 1'b0;
        bus.PCout      = 1'b0;
        bus.Zlowout    = 1'b0;
        bus.Zhighout   = 1'b0;
        bus.MDRout     = 1'b0;
        bus.HIout      = 1'b0;
        bus.LOout      = 1'b0;
        bus.PCin       = 1'b0;
        bus.IRin       = 1'b0;
        bus.RYin       = 1'b0;
        bus.RZin       = 1'b0;
        bus.MARin      = 1'b0;
        bus.MDRin      = 1'b0;
        bus.HIin       = 1'b0;
        bus.LOin       = 1'b0;
        bus.IncPC      = 1'b0;
        bus.Read       = 1'b0;
        bus.ADD        = 1'b0;
        bus.SUB        = 1'b0;
        bus.MUL        = 1'b0;
        bus.DIV        = 1'b0;
        bus.SHR        = 1'b0;
        bus.SHL        = 1'b0;
        bus.ROR        = 1'b0;
        bus.ROL        = 1'b0;
        bus.AND        = 1'b0;
        bus.OR         = 1'b0;
        bus.NEGATE     = 1'b0;
        bus.NOT        = 1'b0;
        bus.GPRin      = '0;
        bus.GPRout     = '0;
        bus.busy       = (state != IDLE);
        bus.instr_done = 1'b0;
        bus.illegal_op = 1'b0;

        case (state)
            IDLE: if (bus.run) state_nxt = T0;
            T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.RZin  = 1'b1;
                state_nxt = T1;
            end
            // PC loads only on the cycle the read completes.
            T1: begin
                bus.Zlowout = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                bus.PCin    = bus.mem_ready;
                if (bus.mem_ready) state_nxt = T2;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_nxt  = T3;
            end
            T3: begin
                state_nxt = T4;
                if (is_alu3) begin
                    bus.GPRout = gpr_sel(rb);
                    bus.RYin   = 1'b1;
                end else if (is_md) begin
                    bus.GPRout = gpr_sel(ra);
                    bus.RYin   = 1'b1;
                end else if (is_un) begin
                    bus.GPRout = gpr_sel(rb);
                    bus.RZin   = 1'b1;
                    op_go      = 1'b1;
                end else begin
                    bus.illegal_op = 1'b1;
                    state_nxt      = bus.run ? T0 : IDLE;
                end
            end
            T4: begin
                if (is_un) begin
                    bus.Zlowout    = 1'b1;
                    bus.GPRin      = gpr_sel(ra);
                    bus.instr_done = 1'b1;
                    state_nxt      = bus.run ? T0 : IDLE;
                end else begin
                    bus.GPRout = is_md ? gpr_sel(rb) : gpr_sel(rc);
                    bus.RZin   = 1'b1;
                    op_go      = 1'b1;
                    state_nxt  = T5;
                end
            end
            T5: begin
                bus.Zlowout = 1'b1;
                if (is_md) begin
`ifdef CU_MULDIV_EN
                    bus.LOin = 1'b1;
`endif
                    state_nxt = T6;
                end else begin
                    bus.GPRin      = gpr_sel(ra);
                    bus.instr_done = 1'b1;
                    state_nxt      = bus.run ? T0 : IDLE;
                end
            end
            T6: begin
`ifdef CU_MULDIV_EN
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
`endif
                bus.instr_done = 1'b1;
                state_nxt      = bus.run ? T0 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (op_go) begin
            case (opc)
                5'b00011: bus.ADD    = 1'b1;
                5'b00100: bus.SUB    = 1'b1;
                5'b00101: bus.SHR    = 1'b1;
                5'b00110: bus.SHL    = 1'b1;
                5'b00111: bus.ROR    = 1'b1;
                5'b01000: bus.ROL    = 1'b1;
                5'b01001: bus.AND    = 1'b1;
                5'b01010: bus.OR     = 1'b1;
`ifdef CU_MULDIV_EN
                5'b01111: bus.MUL    = 1'b1;
                5'b10000: bus.DIV    = 1'b1;
`endif
                5'b10001: bus.NEGATE = 1'b1;
                5'b10010: bus.NOT    = 1'b1;
                default:  ;
            endcase
        end
    end
endmodule

// File: doc/muldiv_control_unit.md
# muldiv_control_unit

- Hardwired control sequencer that drives the Phase 2 bus datapath's control inputs.
- Fetches each instruction over T0–T2 and decodes the 32-bit instruction word in the low bits of `IRVal`.
- Issues per-state register enables, tri-state selects and ALU op strobes for register-register ALU, single-operand, MUL and DIV instructions.
- Sits between the datapath and the memory subsystem; `mem_ready` stretches the fetch read.

## Interface
Parameters:
- `BITS`, 64: datapath/IR width; instruction fields come from `IRVal[31:0]`.
- `REGISTERS`, 16: general-purpose register count; width of `GPRin`/`GPRout`.

Ports:
- `Clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: level; allows leaving IDLE and starting the next fetch.
- `mem_ready` in 1: memory read data valid on `Mdatain` this cycle.
- `IRVal` in BITS: instruction register contents.
- `PCout`, `Zlowout`, `Zhighout`, `MDRout`, `HIout`, `LOout` out 1 each: bus drive selects.
- `PCin`, `IRin`, `RYin`, `RZin`, `MARin`, `MDRin`, `HIin`, `LOin`, `IncPC`, `Read` out 1 each: load enables / memory read.
- `ADD`, `SUB`, `MUL`, `DIV`, `SHR`, `SHL`, `ROR`, `ROL`, `AND`, `OR`, `NEGATE`, `NOT` out 1 each: ALU op strobes, at most one high.
- `GPRin`, `GPRout` out REGISTERS: one-hot or zero register enables.
- `busy` out 1: high in every state except IDLE.
- `instr_done` out 1: one-cycle pulse in the last execute state.
- `illegal_op` out 1: one-cycle pulse when T3 sees an undecoded opcode.

## Operation
- State register: IDLE, T0, T1, T2, T3, T4, T5, T6.
- All outputs are combinational decodes of the state register and `IRVal`; every unlisted output is 0.
- Instruction fields:
  - opcode = `IR[31:27]`; Ra = `IR[26:23]`; Rb = `IR[22:19]`; Rc = `IR[18:15]`.
  - A register index ≥ REGISTERS selects no register, so the enable vector is all-zero.
- Opcodes:
  - add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010.
  - mul 01111, div 10000, neg 10001, not 10010.
- IDLE: no outputs. Goes to T0 when `run`=1.
- T0: `PCout`, `MARin`, `IncPC`, `RZin`.
- T1: `Zlowout`, `PCin`, `Read`, `MDRin`.
  - Holds in T1 while `mem_ready`=0.
  - `PCin` is asserted only in the cycle where `mem_ready`=1, so PC loads exactly once.
- T2: `MDRout`, `IRin`.
- T3:
  - 3-reg ALU ops: `GPRout[Rb]`, `RYin`.
  - mul/div: `GPRout[Ra]`, `RYin`.
  - neg/not: `GPRout[Rb]`, op strobe, `RZin`.
  - Other opcodes: `illegal_op` pulse, then the end-of-instruction transition.
- T4:
  - 3-reg ALU ops: `GPRout[Rc]`, op strobe, `RZin`.
  - mul/div: `GPRout[Rb]`, op strobe, `RZin`.
  - neg/not: `Zlowout`, `GPRin[Ra]`, `instr_done`; end.
- T5:
  - 3-reg ALU ops: `Zlowout`, `GPRin[Ra]`, `instr_done`; end.
  - mul/div: `Zlowout`, `LOin`.
- T6 (mul/div only): `Zhighout`, `HIin`, `instr_done`; end.
- End of instruction: go to T0 if `run`=1, else IDLE.
- `run` is sampled only in IDLE and at the end of an instruction. Dropping it mid-instruction does not abort.

## Timing
- Reset:
  - `reset`=1 at a rising edge forces IDLE at that edge, overriding any transition, including mid-instruction.
  - All outputs are 0 in the following cycle.
- Fetch length: 3 cycles plus (cycles `mem_ready` is held low in T1).
- Instruction length with `mem_ready`=1 from T0, T0 to last state:
  - 3-reg ALU: 6 cycles.
  - neg/not: 5 cycles.
  - mul/div: 7 cycles.
  - illegal: 4 cycles.
- Back-to-back instructions: with `run`=1, the state after the last execute state is T0 with no bubble.
- The datapath captures on the rising edge that ends each state. Every strobe is valid for that full state.
- `IRVal` must be stable from T3 onward. The block does not latch it.

## Configuration
- `CU_MULDIV_EN`:
  - Defined: mul (01111) and div (10000) decode and use T3–T6 as above.
  - Undefined: both are illegal opcodes. They pulse `illegal_op` in T3, and T6 is unreachable.
  - `MUL`, `DIV`, `LOin`, `HIin`, `Zhighout` are tied to 0.

## Test plan
- Reset mid-T4 of an add: the next cycle is IDLE with all outputs 0. `run`=1 then gives T0 with `PCout`=`MARin`=`IncPC`=`RZin`=1.
- `IRVal`=0x4A920000 (and R5,R2,R4), `mem_ready`=1:
  - T3: `GPRout`=0x0004 and `RYin`.
  - T4: `GPRout`=0x0010, `AND`, `RZin`.
  - T5: `Zlowout`, `GPRin`=0x0020, `instr_done`.
- `IRVal`=0x79200000 (mul R2,R4):
  - T3: `GPRout`=0x0004.
  - T4: `GPRout`=0x0010, `MUL`, `RZin`.
  - T5: `Zlowout`+`LOin`.
  - T6: `Zhighout`+`HIin`+`instr_done`.
- `mem_ready` low for 3 cycles in T1: T1 lasts 4 cycles, `Read`/`MDRin` stay high throughout, and `PCin` is high only in the 4th cycle.
- `IRVal`=0xF8000000 (opcode 11111): `illegal_op` pulses in T3, no `GPRin` bit is ever set, and the next state is T0 (`run`=1) or IDLE (`run`=0).
- Build without `CU_MULDIV_EN`, `IRVal`=0x79200000: `illegal_op` pulses in T3, and `MUL`/`LOin`/`HIin` stay 0.
